// File: rtl/mem_copy_master_if.sv
// mem_copy_master_if: picorv32 native memory bus between the DMA initiator and the responder.
interface mem_copy_master_if;
   logic        mem_valid;
   logic        mem_instr;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );
   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_copy_master.sv
// mem_copy_master: word-copy DMA initiator on the picorv32 native bus with a ready timeout.
// Define DMA_FILL_EN to enable pattern-fill transfers (fill_mode/fill_data).
module mem_copy_master #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [15:0] len_words,
   input  logic        fill_mode,
   input  logic [31:0] fill_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   mem_copy_master_if.master bus
);
   localparam logic [2:0] IDLE = 3'd0, RD = 3'd1, RGAP = 3'd2, WR = 3'd3, WGAP = 3'd4, DONE = 3'd5;
   logic [2:0]  state;
   logic [31:0] src, dst;
   logic [15:0] cnt, wcnt;
   logic        fmode, fill, bad, tmo;
`ifdef DMA_FILL_EN
   assign fill = fill_mode;
`else
   logic unused_fill;
   assign fill = 1'b0;
   assign unused_fill = fill_mode;
`endif
   assign bad = |{src_addr[1:0], dst_addr[1:0]};
   // wcnt holds the wait cycles already spent; this cycle would be the TIMEOUT-th
   assign tmo = wcnt == 16'(TIMEOUT - 1);
   assign bus.mem_valid = state == RD || state == WR;
   assign bus.mem_instr = 1'b0;
   assign busy = state inside {RD, RGAP, WR, WGAP};
   assign done = state == DONE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         err <= 1'b0;
         src <= '0;
         dst <= '0;
         cnt <= '0;
         wcnt <= '0;
         fmode <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_wdata <= '0;
         bus.mem_wstrb <= '0;
      end else begin
         wcnt <= (bus.mem_valid && !bus.mem_ready) ? wcnt + 16'd1 : '0;
         case (state)
            IDLE: if (start) begin
               src <= src_addr;
               dst <= dst_addr;
               cnt <= len_words;
               fmode <= fill;
               err <= bad;
               if (bad || len_words == 16'd0) state <= DONE;
               else if (fill) begin
                  state <= WR;
                  bus.mem_addr <= dst_addr;
                  bus.mem_wdata <= fill_data;
                  bus.mem_wstrb <= 4'hF;
               end else begin
                  state <= RD;
                  bus.mem_addr <= src_addr;
                  bus.mem_wstrb <= 4'h0;
               end
            end
            RD: if (bus.mem_ready) begin
               bus.mem_wdata <= bus.mem_rdata;
               state <= RGAP;
            end else if (tmo) begin
               err <= 1'b1;
               state <= DONE;
            end
            RGAP: begin
               state <= WR;
               bus.mem_addr <= dst;
               bus.mem_wstrb <= 4'hF;
            end
            WR: if (bus.mem_ready) begin
               cnt <= cnt - 16'd1;
               src <= src + 32'd4;
               dst <= dst + 32'd4;
               state <= cnt == 16'd1 ? DONE : WGAP;
            end else if (tmo) begin
               err <= 1'b1;
               state <= DONE;
            end
            WGAP: begin
               state <= fmode ? WR : RD;
               bus.mem_addr <= fmode ? dst : src;
               bus.mem_wstrb <= fmode ? 4'hF : 4'h0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: scoreboard bench; expected bus transactions and done pulses are queued at stimulus time.
module tb_mem_copy_master;
   logic        clk, reset, start, fill_mode, busy, done, err, load;
   logic [31:0] src_addr, dst_addr, fill_data, cyc, vcnt, v0;
   logic [15:0] len_words;
   int          wc, ws, tests, fails;
   logic [31:0] ram [0:1023];
   localparam logic [31:0] PAT [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
   typedef struct packed {logic [31:0] a; logic [3:0] s; logic [31:0] d;} tx_t;
   typedef struct packed {logic e; logic [31:0] c;} dn_t;
   tx_t         exp_tx[$];
   dn_t         exp_done[$];
   tx_t         t;
   dn_t         dn;
   logic        pv, pr;
   logic [31:0] pa, pd;
   logic [3:0]  ps;

   mem_copy_master_if bus();
   mem_copy_master #(.TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len_words(len_words), .fill_mode(fill_mode), .fill_data(fill_data),
      .busy(busy), .done(done), .err(err), .bus(bus)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // responder: RAM below 0x1000, ws wait states per transaction, nothing mapped above
   always_comb begin
      bus.mem_ready = bus.mem_valid && bus.mem_addr < 32'h1000 && wc == ws;
      bus.mem_rdata = ram[bus.mem_addr[11:2]];
   end
   always @(posedge clk) begin
      cyc <= reset ? 32'd0 : cyc + 32'd1;
      vcnt <= reset ? 32'd0 : vcnt + {31'd0, bus.mem_valid};
      wc <= (bus.mem_valid && !bus.mem_ready) ? wc + 1 : 0;
      if (load) for (int i = 0; i < 4; i++) ram[10'(64 + i)] <= PAT[i];
      else if (bus.mem_valid && bus.mem_ready && bus.mem_wstrb == 4'hF) ram[bus.mem_addr[11:2]] <= bus.mem_wdata;
   end

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // monitor: pops the scoreboard on every accepted transaction and every done pulse
   always @(negedge clk) begin
      if (bus.mem_valid && bus.mem_ready) begin
         chk("tx_expected", exp_tx.size() != 0, 1);
         if (exp_tx.size() != 0) begin
            t = exp_tx.pop_front();
            chk("tx", {bus.mem_addr, bus.mem_wstrb, bus.mem_wstrb == 4'h0 ? 32'h0 : bus.mem_wdata},
                {t.a, t.s, t.s == 4'h0 ? 32'h0 : t.d});
         end
      end
      if (pv && !pr && bus.mem_valid)
         chk("stable_in_wait", {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, {pa, pd, ps});
      if (done) begin
         chk("done_expected", exp_done.size() != 0, 1);
         if (exp_done.size() != 0) begin
            dn = exp_done.pop_front();
            chk("done_err_cycle", {err, cyc}, {dn.e, dn.c});
         end
      end
      pv <= bus.mem_valid;
      pr <= bus.mem_ready;
      pa <= bus.mem_addr;
      pd <= bus.mem_wdata;
      ps <= bus.mem_wstrb;
   end

   task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         exp_tx.push_back({s + 32'(4 * i), 4'h0, 32'h0});
         exp_tx.push_back({d + 32'(4 * i), 4'hF, PAT[i]});
      end
   endtask

   // dc: expected done cycle relative to the start edge k, or -1 for no done pulse
   task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                     input logic f, input logic [31:0] fd, input logic e, input int dc);
      @(negedge clk);
      if (dc >= 0) exp_done.push_back({e, cyc + 32'(dc)});
      src_addr = s;
      dst_addr = d;
      len_words = n;
      fill_mode = f;
      fill_data = fd;
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic drain(input string nm);
      int i = 0;
      while (exp_done.size() != 0 && i < 400) begin
         @(negedge clk);
         i++;
      end
      chk({nm, "_done_left"}, exp_done.size(), 0);
      chk({nm, "_tx_left"}, exp_tx.size(), 0);
      exp_done.delete();
      exp_tx.delete();
      @(negedge clk);
   endtask

   initial begin
      int nw, i;
      tests = 0;
      fails = 0;
      reset = 1;
      start = 0;
      load = 1;
      ws = 0;
      fill_mode = 0;
      fill_data = 0;
      src_addr = 0;
      dst_addr = 0;
      len_words = 0;
      repeat (2) @(negedge clk);
      load = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_valid", bus.mem_valid, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_wstrb", bus.mem_wstrb, 0);
      chk("rst_instr", bus.mem_instr, 0);
      reset = 0;

      push_copy(32'h100, 32'h200, 4);
      go(32'h100, 32'h200, 16'd4, 1'b0, 32'h0, 1'b0, 16);
      chk("busy_k1", busy, 1);
      chk("valid_k1", bus.mem_valid, 1);
      drain("copy0");
      for (int k = 0; k < 4; k++) chk("ram_copy0", ram[10'(128 + k)], PAT[k]);

      ws = 2;
      push_copy(32'h100, 32'h280, 4);
      go(32'h100, 32'h280, 16'd4, 1'b0, 32'h0, 1'b0, 32);
      drain("copy_ws2");
      for (int k = 0; k < 4; k++) chk("ram_copy_ws2", ram[10'(160 + k)], PAT[k]);

      ws = 0;
      v0 = vcnt;
      go(32'h0004_0000, 32'h200, 16'd1, 1'b0, 32'h0, 1'b1, 9);
      drain("timeout");
      chk("tmo_valid_cycles", vcnt - v0, 8);
      chk("err_sticky", err, 1);

      v0 = vcnt;
      go(32'h100, 32'h200, 16'd0, 1'b0, 32'h0, 1'b0, 1);
      drain("len0");
      chk("len0_no_valid", vcnt - v0, 0);

      v0 = vcnt;
      go(32'h102, 32'h200, 16'd4, 1'b0, 32'h0, 1'b1, 1);
      drain("misalign");
      chk("misalign_no_valid", vcnt - v0, 0);

      ws = 2;
      exp_tx.push_back({32'h100, 4'h0, 32'h0});
      exp_tx.push_back({32'h200, 4'hF, PAT[0]});
      exp_tx.push_back({32'h104, 4'h0, 32'h0});
      go(32'h100, 32'h200, 16'd4, 1'b0, 32'h0, 1'b0, -1);
      nw = 0;
      i = 0;
      while (nw < 2 && i < 100) begin
         @(negedge clk);
         i++;
         if (bus.mem_valid && bus.mem_wstrb == 4'hF && wc == 0) nw++;
      end
      chk("rst_reach_wr2", nw, 2);
      reset = 1;
      @(negedge clk);
      chk("midrst_valid", bus.mem_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_addr", bus.mem_addr, 0);
      reset = 0;
      repeat (10) @(negedge clk);
      chk("midrst_tx_left", exp_tx.size(), 0);
      exp_tx.delete();

      ws = 0;
      push_copy(32'h100, 32'h380, 2);
      go(32'h100, 32'h380, 16'd2, 1'b0, 32'h0, 1'b0, 8);
      drain("after_rst");
      for (int k = 0; k < 2; k++) chk("ram_after_rst", ram[10'(224 + k)], PAT[k]);

`ifdef DMA_FILL_EN
      for (int k = 0; k < 3; k++) exp_tx.push_back({32'h300 + 32'(4 * k), 4'hF, 32'hDEADBEEF});
      go(32'h100, 32'h300, 16'd3, 1'b1, 32'hDEADBEEF, 1'b0, 6);
      drain("fill");
      for (int k = 0; k < 3; k++) chk("ram_fill", ram[10'(192 + k)], 32'hDEADBEEF);
`else
      push_copy(32'h100, 32'h300, 3);
      go(32'h100, 32'h300, 16'd3, 1'b1, 32'hDEADBEEF, 1'b0, 12);
      drain("fill_off");
      for (int k = 0; k < 3; k++) chk("ram_fill_off", ram[10'(192 + k)], PAT[k]);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
